// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SCLK/CS_n/MOSI in the clock_i domain,
// deserialises MOSI into words and shifts a host-loaded word out on MISO.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             SCLK_i,
    input  logic             CS_ni,
    input  logic             MOSI_i,
    output logic             MISO_o,
    output logic             MISO_oe_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_load_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             frame_err_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] prime;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   armed;
    logic [WIDTH-1:0]       tx_hold;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-2:0]       rx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [WIDTH-1:0] rx_next;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    // A select is only honoured once CS_n has been seen high after reset,
    // so a frame already running at reset release is ignored.
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;

    assign rx_next = {rx_shift, mosi_s};

    assign busy_o    = (state == ACTIVE);
    assign MISO_oe_o = (state == ACTIVE);
    assign MISO_o    = (state == ACTIVE) & tx_shift[WIDTH-1];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            prime     <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_ni};
            prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            // prime marks the point where cs_s reflects the pin, not the preset
            if (prime[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            tx_hold     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            bit_cnt     <= '0;
            reload      <= 1'b0;
        end else begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            if (tx_load_i) tx_hold <= tx_data_i;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_shift <= tx_load_i ? tx_data_i : tx_hold;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                        reload   <= 1'b0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        if (bit_cnt != '0) frame_err_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next[WIDTH-2:0];
                            if (bit_cnt == LAST_BIT) begin
                                rx_data_o  <= rx_next;
                                rx_valid_o <= 1'b1;
                                bit_cnt    <= '0;
                                reload     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // The fall after a word's last bit presents the next word's MSB
                        if (sclk_fall) begin
                            if (reload) begin
                                tx_shift <= tx_hold;
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
